// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: E-stage multiply/divide unit for the pipelined MIPS core.
// The result is computed in the start cycle and held in a pending register.
// It is written to HI/LO once the fixed latency has elapsed.
// busy/stall_md let the D-stage hazard logic hold HI/LO users until the unit is free.
module md_unit_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        md_use_d,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        busy,
   output logic        stall_md
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [31:0]    hi_q, hi_d;
   logic [31:0]    lo_q, lo_d;
   logic [63:0]    pend_q, pend_d;
   logic           pend_wr_q, pend_wr_d;

   logic [63:0]    prod_s;
   logic [63:0]    prod_u;
   logic           rt_nz;
   logic [31:0]    divisor_u;
   logic [31:0]    quo_u, rem_u;
   logic [31:0]    mag_rs, mag_rt, mag_rt_safe;
   logic [31:0]    quo_mag, rem_mag;
   logic [31:0]    quo_s, rem_s;
   logic           op_is_md;

   // Arithmetic datapath. Signed division works on magnitudes, so the most-negative
   // dividend over -1 wraps to 0x80000000 without relying on signed-divide overflow.
   // A zero divisor is replaced by 1 only to keep the divider defined; its result is never written.
   always_comb begin
      prod_s      = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
      prod_u      = {32'd0, rs_data} * {32'd0, rt_data};
      rt_nz       = |rt_data;
      divisor_u   = rt_nz ? rt_data : 32'd1;
      quo_u       = rs_data / divisor_u;
      rem_u       = rs_data % divisor_u;
      mag_rs      = rs_data[31] ? (32'd0 - rs_data) : rs_data;
      mag_rt      = rt_data[31] ? (32'd0 - rt_data) : rt_data;
      mag_rt_safe = rt_nz ? mag_rt : 32'd1;
      quo_mag     = mag_rs / mag_rt_safe;
      rem_mag     = mag_rs % mag_rt_safe;
      quo_s       = (rs_data[31] ^ rt_data[31]) ? (32'd0 - quo_mag) : quo_mag;
      rem_s       = rs_data[31] ? (32'd0 - rem_mag) : rem_mag;
   end

   // Busy covers the start cycle too, so a back-to-back HI/LO user in D stalls immediately
   always_comb begin
      op_is_md = (md_op >= 3'd1) && (md_op <= 3'd4);
      busy     = (state_q == BUSY) || (start && op_is_md);
      stall_md = md_use_d && busy;
   end

   // Sequencer next-state: launch from IDLE, count down in BUSY, commit HI/LO on the last count
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_d    = pend_q;
      pend_wr_d = pend_wr_q;
      if (state_q == IDLE) begin
         if (start) begin
            case (md_op)
               3'd1: begin
                  pend_d    = prod_s;
                  pend_wr_d = 1'b1;
                  cnt_d     = MULT_N;
                  state_d   = BUSY;
               end
               3'd2: begin
                  pend_d    = prod_u;
                  pend_wr_d = 1'b1;
                  cnt_d     = MULT_N;
                  state_d   = BUSY;
               end
               3'd3: begin
                  pend_d    = {rem_s, quo_s};
                  pend_wr_d = rt_nz;
                  cnt_d     = DIV_N;
                  state_d   = BUSY;
               end
               3'd4: begin
                  pend_d    = {rem_u, quo_u};
                  pend_wr_d = rt_nz;
                  cnt_d     = DIV_N;
                  state_d   = BUSY;
               end
               3'd5: hi_d = rs_data;
               3'd6: lo_d = rs_data;
               default: ;
            endcase
         end
      end else begin
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            if (pend_wr_q) begin
               hi_d = pend_q[63:32];
               lo_d = pend_q[31:0];
            end
            cnt_d     = '0;
            pend_wr_d = 1'b0;
            state_d   = IDLE;
         end
      end
   end

   // State and HI/LO registers; reset discards any in-flight operation
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_q    <= '0;
         pend_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_q    <= pend_d;
         pend_wr_q <= pend_wr_d;
      end
   end

   assign hi_out = hi_q;
   assign lo_out = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: table-driven bench for md_unit_ctrl with a HI/LO scoreboard
module tb_md_unit_ctrl;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        md_use_d;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        busy;
   logic        stall_md;

   int numChecks = 0;
   int numErrors = 0;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .md_op(md_op),
      .rs_data(rs_data),
      .rt_data(rt_data),
      .md_use_d(md_use_d),
      .hi_out(hi_out),
      .lo_out(lo_out),
      .busy(busy),
      .stall_md(stall_md)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mkVec(string n, logic [2:0] op, logic [31:0] rs, logic [31:0] rt,
                                  logic [31:0] hi, logic [31:0] lo, int cycles);
      vec_t v;
      v.name = n; v.op = op; v.rs = rs; v.rt = rt; v.hi = hi; v.lo = lo; v.cycles = cycles;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      numChecks++;
      if (actual !== expected) begin
         numErrors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
      start   = s;
      md_op   = op;
      rs_data = rs;
      rt_data = rt;
   endtask

   // Called just after a rising edge; returns just after the next rising edge
   task automatic writeHiLo(input logic [2:0] op, input logic [31:0] value);
      applyStimulus(1'b1, op, value, 32'd0);
      @(posedge clk); #1;
      applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
   endtask

   task automatic runOp(input vec_t v);
      exp_t e;
      int   n;
      bit   done;
      e.hi = v.hi;
      e.lo = v.lo;
      applyStimulus(1'b1, v.op, v.rs, v.rt);
      sb.push_back(e);
      @(negedge clk);
      checkOutput({v.name, "_busy_start"}, 64'(busy), 64'd1);
      @(posedge clk); #1;
      applyStimulus(1'b0, 3'd0, $urandom, $urandom);
      n = 0;
      done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (busy) n++;
         else done = 1;
      end
      if (!done) checkOutput({v.name, "_busy_timeout"}, 64'(busy), 64'd0);
      checkOutput({v.name, "_busy_cycles"}, 64'(n), 64'(v.cycles));
      if (sb.size() == 0) begin
         checkOutput({v.name, "_scoreboard_empty"}, 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         checkOutput({v.name, "_hi"}, 64'(hi_out), 64'(e.hi));
         checkOutput({v.name, "_lo"}, 64'(lo_out), 64'(e.lo));
      end
      @(posedge clk); #1;
   endtask

   initial begin
      vecs.push_back(mkVec("mult_neg3x5",  3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5));
      vecs.push_back(mkVec("multu_ffx2",   3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5));
      vecs.push_back(mkVec("mult_minxmin", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5));
      vecs.push_back(mkVec("multu_max",    3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5));
      vecs.push_back(mkVec("div_neg7by2",  3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10));
      vecs.push_back(mkVec("divu_neg7by2", 3'd4, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10));
      vecs.push_back(mkVec("div_overflow", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10));
      vecs.push_back(mkVec("div_7bym2",    3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10));
      vecs.push_back(mkVec("div_m7bym2",   3'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 10));
      vecs.push_back(mkVec("divu_maxby16", 3'd4, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10));

      applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
      md_use_d = 1'b0;
      reset    = 1'b1;
      #1 reset = 1'b0;
      #2;
      checkOutput("por_hi", 64'(hi_out), 64'd0);
      checkOutput("por_lo", 64'(lo_out), 64'd0);
      checkOutput("por_busy", 64'(busy), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      // Reset clears values loaded through mthi/mtlo
      writeHiLo(3'd5, 32'h12345678);
      writeHiLo(3'd6, 32'h12345678);
      @(negedge clk);
      checkOutput("mthi_load", 64'(hi_out), 64'h12345678);
      checkOutput("mtlo_load", 64'(lo_out), 64'h12345678);
      reset = 1'b0;
      #1;
      checkOutput("reset_hi", 64'(hi_out), 64'd0);
      checkOutput("reset_lo", 64'(lo_out), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      // Start with op 7 or 0 does nothing
      writeHiLo(3'd6, 32'h00000077);
      applyStimulus(1'b1, 3'd7, 32'hDEADBEEF, 32'd3);
      @(negedge clk);
      checkOutput("op7_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      applyStimulus(1'b1, 3'd0, 32'hDEADBEEF, 32'd3);
      @(posedge clk); #1;
      applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput("nop_hi", 64'(hi_out), 64'd0);
      checkOutput("nop_lo", 64'(lo_out), 64'h77);
      @(posedge clk); #1;

      // Main table
      foreach (vecs[i]) runOp(vecs[i]);

      // Divide by zero keeps HI/LO
      writeHiLo(3'd5, 32'hAAAA0000);
      writeHiLo(3'd6, 32'h0000BBBB);
      runOp(mkVec("div_by_zero", 3'd3, 32'd9, 32'd0, 32'hAAAA0000, 32'h0000BBBB, 10));

      // Stall and start-while-busy
      writeHiLo(3'd5, 32'h00000055);
      writeHiLo(3'd6, 32'h00000066);
      @(negedge clk);
      md_use_d = 1'b1;
      #1;
      checkOutput("stall_idle", 64'(stall_md), 64'd0);
      @(posedge clk); #1;
      applyStimulus(1'b1, 3'd1, 32'd6, 32'd7);
      @(negedge clk);
      checkOutput("stall_start", 64'(stall_md), 64'd1);
      @(posedge clk); #1;
      applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("stall_busy", 64'(stall_md), 64'd1);
         if (i == 0) begin
            applyStimulus(1'b1, 3'd5, 32'd1, 32'd0);
         end else if (i == 1) begin
            checkOutput("mthi_ignored", 64'(hi_out), 64'h55);
            applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
         end
      end
      @(negedge clk);
      checkOutput("stall_release", 64'(stall_md), 64'd0);
      checkOutput("stall_mult_hi", 64'(hi_out), 64'd0);
      checkOutput("stall_mult_lo", 64'(lo_out), 64'd42);
      md_use_d = 1'b0;
      @(posedge clk); #1;

      // Reset in the middle of a divide
      applyStimulus(1'b1, 3'd3, 32'd100, 32'd7);
      @(posedge clk); #1;
      applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
      for (int i = 0; i < 4; i++) @(negedge clk);
      checkOutput("midop_busy_before", 64'(busy), 64'd1);
      reset = 1'b0;
      #1;
      checkOutput("midop_busy", 64'(busy), 64'd0);
      checkOutput("midop_hi", 64'(hi_out), 64'd0);
      checkOutput("midop_lo", 64'(lo_out), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 15; i++) @(negedge clk);
      checkOutput("midop_no_late_busy", 64'(busy), 64'd0);
      checkOutput("midop_no_late_lo", 64'(lo_out), 64'd0);
      @(posedge clk); #1;
      runOp(mkVec("mult_3x4_after_reset", 3'd1, 32'd3, 32'd4, 32'd0, 32'd12, 5));

      $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
      $finish;
   end

endmodule
